data_bus_arbiter: RTL

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

---
 rtl/data_bus_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/data_bus_arbiter.sv
// Two-requester arbiter in front of one shared slave, with a grant watchdog and a one-cycle cooldown.
// Define DATA_BUS_ARB_RR_EN for round-robin on simultaneous requests; the default is fixed priority to requester 0.
module data_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_addr,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [2:0]  m0_memType,
    input  logic [31:0] m0_dataOut,
    output logic [31:0] m0_dataIn,
    output logic        m0_ready,
    input  logic [31:0] m1_addr,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [2:0]  m1_memType,
    input  logic [31:0] m1_dataOut,
    output logic [31:0] m1_dataIn,
    output logic        m1_ready,
    output logic [31:0] s_addr,
    output logic        s_read,
    output logic        s_write,
    output logic [2:0]  s_memType,
    output logic [31:0] s_dataOut,
    input  logic [31:0] s_dataIn,
    input  logic        s_ready,
    output logic [1:0]  grant,
    output logic        timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, COOLDOWN} state_t;

    state_t           state;
    logic [CNT_W-1:0] wd_cnt;
    logic             m0_req;
    logic             m1_req;
    logic             own_req;
    logic             pick1;

    assign m0_req  = m0_read | m0_write;
    assign m1_req  = m1_read | m1_write;
    assign own_req = (state == GRANT1) ? m1_req : m0_req;

`ifdef DATA_BUS_ARB_RR_EN
    // rr_ptr names the requester favoured on the next tie
    logic rr_ptr;
    assign pick1 = m1_req & (~m0_req | rr_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (state == IDLE && (m0_req || m1_req)) begin
            rr_ptr <= ~pick1;
        end
    end
`else
    assign pick1 = m1_req & ~m0_req;
`endif

    // Watchdog aborts in the cycle the grant has lasted TIMEOUT_CYCLES cycles; s_ready wins that tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state  <= pick1 ? GRANT1 : GRANT0;
                        wd_cnt <= '0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (s_ready || !own_req) begin
                        state <= COOLDOWN;
                    end else if (wd_cnt == CNT_LAST) begin
                        state   <= COOLDOWN;
                        timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_addr    = '0;
        s_read    = 1'b0;
        s_write   = 1'b0;
        s_memType = '0;
        s_dataOut = '0;
        grant     = 2'b00;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        if (state == GRANT0) begin
            s_addr    = m0_addr;
            s_read    = m0_read;
            s_write   = m0_write;
            s_memType = m0_memType;
            s_dataOut = m0_dataOut;
            grant     = 2'b01;
            m0_ready  = s_ready;
        end else if (state == GRANT1) begin
            s_addr    = m1_addr;
            s_read    = m1_read;
            s_write   = m1_write;
            s_memType = m1_memType;
            s_dataOut = m1_dataOut;
            grant     = 2'b10;
            m1_ready  = s_ready;
        end
    end

    assign m0_dataIn = s_dataIn;
    assign m1_dataIn = s_dataIn;

endmodule
